// File: rtl/des_pkg.sv
// Shared DES definitions: FIPS 46-3 tables, key shift schedule, S-boxes,
// FSM encoding and the bit-permutation helpers used by the round logic.
package des_pkg;

    localparam int ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // All tables use 1-based DES bit numbers; bit n of a W-bit vector is [W-n].
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Row-major: entry index = row*16 + column.
    localparam int SBOX_TAB [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TAB[i])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TAB[i])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = 56'd0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TAB[i])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = 48'd0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TAB[i])];
        return y;
    endfunction

    // Cipher function f(R,K) = P(S(E(R) xor K)).
    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s_out;
        logic [31:0] y;
        logic [5:0]  six;
        logic [5:0]  idx;
        x = 48'd0;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_TAB[i])];
        x = x ^ k;
        s_out = 32'd0;
        for (int s = 0; s < 8; s++) begin
            six = x[6'(47 - 6 * s) -: 6];
            idx = {six[5], six[0], six[4:1]};
            s_out[5'(31 - 4 * s) -: 4] = 4'(SBOX_TAB[s][idx]);
        end
        y = 32'd0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s_out[5'(32 - P_TAB[i])];
        return y;
    endfunction

    // Rotation amount for round 1..16; out-of-range rounds get a harmless 1.
    function automatic logic [1:0] shift_amt(input logic [4:0] round);
        logic [1:0] amt;
        if ((round >= 5'd1) && (round <= 5'd16)) begin
            amt = 2'(SHIFT_TAB[4'(round - 5'd1)]);
        end else begin
            amt = 2'd1;
        end
        return amt;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round: key-half rotation, subkey selection and Feistel step.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [27:0] c_in,
    input  logic [27:0] d_in,
    input  logic [1:0]  shift,
    output logic [31:0] l_out,
    output logic [31:0] r_out,
    output logic [27:0] c_out,
    output logic [27:0] d_out
);

    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic [47:0] subkey;

    // Rotate the key halves, derive K_i and apply the Feistel swap.
    always_comb begin
        c_rot  = c_in;
        d_rot  = d_in;
        if (shift == 2'd2) begin
            c_rot = {c_in[25:0], c_in[27:26]};
            d_rot = {d_in[25:0], d_in[27:26]};
        end else begin
            c_rot = {c_in[26:0], c_in[27]};
            d_rot = {d_in[26:0], d_in[27]};
        end
        subkey = perm_pc2({c_rot, d_rot});
        c_out  = c_rot;
        d_out  = d_rot;
        l_out  = r_in;
        r_out  = l_in ^ feistel(r_in, subkey);
    end

endmodule

// File: rtl/des_core.sv
// Iterative DES encryptor: loads a block, runs 16 rounds (one per clock),
// then publishes the ciphertext with a one-cycle valid pulse.
module des_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] plain_text,
    input  logic [63:0] key_din,
    output logic [63:0] cipher_text,
    output logic        dat_valid
);

    state_t      state;
    logic [4:0]  round;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [31:0] l_nxt;
    logic [31:0] r_nxt;
    logic [27:0] c_nxt;
    logic [27:0] d_nxt;
    logic [63:0] ip_val;
    logic [55:0] pc1_val;

    assign ip_val  = perm_ip(plain_text);
    assign pc1_val = perm_pc1(key_din);

    des_round u_round (
        .l_in  (l_reg),
        .r_in  (r_reg),
        .c_in  (c_reg),
        .d_in  (d_reg),
        .shift (shift_amt(round)),
        .l_out (l_nxt),
        .r_out (r_nxt),
        .c_out (c_nxt),
        .d_out (d_nxt)
    );

    // Control FSM with the datapath registers and registered outputs.
    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            round       <= 5'd0;
            l_reg       <= 32'd0;
            r_reg       <= 32'd0;
            c_reg       <= 28'd0;
            d_reg       <= 28'd0;
            cipher_text <= 64'd0;
            dat_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dat_valid <= 1'b0;
                    if (start) begin
                        l_reg <= ip_val[63:32];
                        r_reg <= ip_val[31:0];
                        c_reg <= pc1_val[55:28];
                        d_reg <= pc1_val[27:0];
                        round <= 5'd1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    dat_valid <= 1'b0;
                    l_reg     <= l_nxt;
                    r_reg     <= r_nxt;
                    c_reg     <= c_nxt;
                    d_reg     <= d_nxt;
                    if (round == 5'(ROUNDS)) begin
                        round <= 5'd0;
                        state <= DONE;
                    end else begin
                        round <= round + 5'd1;
                    end
                end
                DONE: begin
                    // Halves are swapped before the final permutation.
                    cipher_text <= perm_fp({r_reg, l_reg});
                    dat_valid   <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    dat_valid <= 1'b0;
                    round     <= 5'd0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_core.sv
// Directed bench for des_core with a bit-level DES reference model and a
// cycle-by-cycle output comparison.
module tb_des_core;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] plain_text = 64'd0;
    logic [63:0] key_din = 64'd0;
    logic [63:0] cipher_text;
    logic        dat_valid;

    int total = 0;
    int bad   = 0;

    des_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .plain_text  (plain_text),
        .key_din     (key_din),
        .cipher_text (cipher_text),
        .dat_valid   (dat_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference DES: bit n of a W-bit word is [W-n]; subkeys from cumulative
    // rotation; final permutation derived as the inverse of IP.
    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        int          six, row, col;
        for (int n = 1; n <= 48; n++) x[48 - n] = r[32 - E_TAB[n - 1]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = int'(x[47 - 6 * b -: 6]);
            row = ((six >> 5) & 1) * 2 + (six & 1);
            col = (six >> 1) & 15;
            s[31 - 4 * b -: 4] = 4'(SBOX_TAB[b][row * 16 + col]);
        end
        for (int n = 1; n <= 32; n++) y[32 - n] = s[32 - P_TAB[n - 1]];
        return y;
    endfunction

    function automatic logic [63:0] model_des(input logic [63:0] pt, input logic [63:0] key);
        logic [55:0] cd;
        logic [55:0] rot;
        logic [47:0] sub [16];
        logic [63:0] perm;
        logic [63:0] pre;
        logic [63:0] res;
        logic [31:0] l, r, t;
        int          tot;
        for (int n = 1; n <= 56; n++) cd[56 - n] = key[64 - PC1_TAB[n - 1]];
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            tot += SHIFT_TAB[i];
            for (int j = 0; j < 28; j++) begin
                rot[55 - j] = cd[55 - ((j + tot) % 28)];
                rot[27 - j] = cd[27 - ((j + tot) % 28)];
            end
            for (int n = 1; n <= 48; n++) sub[i][48 - n] = rot[56 - PC2_TAB[n - 1]];
        end
        for (int n = 1; n <= 64; n++) perm[64 - n] = pt[64 - IP_TAB[n - 1]];
        l = perm[63:32];
        r = perm[31:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ model_f(r, sub[i]);
            l = r;
            r = t;
        end
        pre = {r, l};
        for (int n = 1; n <= 64; n++) res[64 - IP_TAB[n - 1]] = pre[64 - n];
        return res;
    endfunction

    // Model timing: accept in idle, result 17 edges later, then idle again.
    int          m_busy = 0;
    logic [63:0] m_pending = 64'd0;
    logic [63:0] m_ct = 64'd0;
    logic        m_valid = 1'b0;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_busy  <= 0;
            m_ct    <= 64'd0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy == 0) begin
                if (start) begin
                    m_pending <= model_des(plain_text, key_din);
                    m_busy    <= 17;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_ct    <= m_pending;
                    m_valid <= 1'b1;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        check("cyc_valid", {63'd0, dat_valid}, {63'd0, m_valid});
        check("cyc_cipher", cipher_text, m_ct);
    end

    task automatic wait_pulse(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!dat_valid && cnt < 40);
    endtask

    task automatic run_one(input logic [63:0] pt, input logic [63:0] key,
                           input logic [63:0] exp, input string name);
        int cnt;
        plain_text = pt;
        key_din    = key;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        while (!dat_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_latency"}, 64'(cnt - 1), 64'd17);
        check(name, cipher_text, exp);
    endtask

    initial begin
        int cnt;

        // Pin the reference model to known answers.
        check("model_kat1", model_des(64'h0123456789ABCDEF, 64'h133457799BBCDFF1), 64'h85E813540F0AB405);
        check("model_zero", model_des(64'h0, 64'h0), 64'h8CA64DE9C1B123A7);
        check("model_ones", model_des(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF), 64'h7359B2163E4EDC58);
        check("model_vpt", model_des(64'h95F8A5E5DD31D900, 64'h0101010101010101), 64'h8000000000000000);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cipher", cipher_text, 64'd0);
        check("rst_valid", {63'd0, dat_valid}, 64'd0);
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_valid", {63'd0, dat_valid}, 64'd0);

        // Classic vector, single start pulse.
        run_one(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, "kat1");
        repeat (3) @(negedge clk);

        // Parity bits of the key must not matter.
        run_one(64'h0, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, "key_zero");
        run_one(64'h0, 64'h0101010101010101, 64'h8CA64DE9C1B123A7, "key_parity");

        // start held high: back-to-back blocks every 18 clocks.
        plain_text = 64'hFFFFFFFFFFFFFFFF;
        key_din    = 64'hFFFFFFFFFFFFFFFF;
        start      = 1'b1;
        wait_pulse(cnt);
        check("hold_first", 64'(cnt - 1), 64'd17);
        check("hold_ct0", cipher_text, 64'h7359B2163E4EDC58);
        for (int k = 1; k <= 2; k++) begin
            wait_pulse(cnt);
            check("hold_period", 64'(cnt), 64'd18);
            check("hold_ct", cipher_text, 64'h7359B2163E4EDC58);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Input change during RUN does not disturb the block in flight.
        plain_text = 64'h0;
        key_din    = 64'h0101010101010101;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        plain_text = 64'h95F8A5E5DD31D900;
        wait_pulse(cnt);
        check("midrun_latency", 64'(cnt + 4), 64'd17);
        check("midrun_ct", cipher_text, 64'h8CA64DE9C1B123A7);
        run_one(64'h95F8A5E5DD31D900, 64'h0101010101010101, 64'h8000000000000000, "next_blk");

        // Reset while round 8 is in progress.
        plain_text = 64'h0123456789ABCDEF;
        key_din    = 64'h133457799BBCDFF1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("abort_cipher", cipher_text, 64'd0);
        check("abort_valid", {63'd0, dat_valid}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_quiet", cipher_text, 64'd0);
        run_one(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, "after_rst");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_core.md
Name: des_core

Overview:
- Iterative DES encryption engine: one 64-bit plaintext block and one 64-bit key (FIPS 46-3) in, 64-bit ciphertext out.
- Computes one Feistel round per clock, 16 rounds per block, and flags the result with a one-cycle valid pulse.
- Encrypt-only leaf block for the crypto subsystem; no decrypt mode.

Parameters:
- None. DES geometry (64-bit block, 56-bit effective key, 16 rounds) is fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset. The name follows the codebase; polarity is high despite the suffix.
- start  input  1  level request; sampled only in IDLE.
- plain_text  input  64  plaintext block; bit 63 = DES bit 1.
- key_din  input  64  key including parity bits; bit 63 = DES bit 1. Parity bits (DES bits 8,16,…,64) are ignored.
- cipher_text  output  64  ciphertext; bit 63 = DES bit 1. Holds the last result.
- dat_valid  output  1  one-cycle pulse when cipher_text is updated.

Behaviour:
- Reset (async, rst_n=1): state=IDLE, round counter=0, L/R/C/D registers=0, cipher_text=0, dat_valid=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Load L0||R0 = IP(plain_text) and C0||D0 = PC1(key_din).
  - Go to RUN with round=1.
  - plain_text and key_din are don't-care after E0.
- IDLE, start=0: stay in IDLE; dat_valid=0.
- RUN, edges E1..E16, round i:
  - C/D each rotate left by shift[i] = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
  - K_i = PC2(rotated C||D).
  - L_i = R_{i-1}; R_i = L_{i-1} XOR f(R_{i-1}, K_i).
  - f(R,K) = P(S-boxes(E(R) XOR K)). S1..S8 map 6→4 bits; the row is formed by the outer bits, the column by the inner 4 bits.
  - After E16, go to DONE.
- DONE, edge E17:
  - cipher_text <= FP(R16||L16) (halves swapped before the final permutation).
  - dat_valid <= 1 for exactly this one cycle.
  - state <= IDLE.
- Latency: dat_valid is high in the cycle after E17, i.e. 17 clocks after start is accepted.
- Throughput: one block per 18 clocks with start held high. The next start is accepted at E18 with fresh inputs.
- start asserted during RUN/DONE: ignored; no queuing.
- start held high continuously: back-to-back encryptions; each produces its own dat_valid pulse.
- cipher_text changes only at the DONE edge or on reset; it is stable in between.
- Reset mid-operation: immediate abort to IDLE; outputs return to 0; no dat_valid.
- Permutation tables use standard FIPS 46-3 1-based indexing. Bit n maps to vector index [64-n] (or [32-n], [48-n], [56-n] for the narrower vectors).
- Key-schedule arithmetic is purely combinational from the registered C/D. No multipliers. One round of combinational logic per cycle.

Decomposition:
- Shared package des_pkg holds:
  - Tables IP, FP, E, P, PC1, PC2.
  - The shift schedule.
  - S-boxes S1–S8.
  - Constants for the round count (16) and the state encoding.
  - Permutation helper functions.
- Sub-module des_round: combinational block taking L, R, C, D and the shift amount. It outputs next L, R, C, D. Instantiated once in des_core, which holds the FSM, counter and registers.

Test Plan:
- Reset asserted → cipher_text=0x0000000000000000, dat_valid=0, no pulses while start=0.
- key_din=0x133457799BBCDFF1, plain_text=0x0123456789ABCDEF, start pulsed one cycle → single dat_valid pulse 17 clocks later, cipher_text=0x85E813540F0AB405.
- key_din=0x0000000000000000 and key_din=0x0101010101010101 (parity-only difference), plain_text=0 → both give 0x8CA64DE9C1B123A7.
- key_din=0xFFFFFFFFFFFFFFFF, plain_text=0xFFFFFFFFFFFFFFFF, start held high → dat_valid every 18 clocks, each time 0x7359B2163E4EDC58.
- Change plain_text to 0x95F8A5E5DD31D900 mid-RUN with key 0x0101010101010101 → current result unaffected. The next accepted block yields 0x8000000000000000.
- Assert reset during round 8 → immediate outputs 0, no dat_valid. After release with start=1, a fresh correct result arrives 17 clocks after acceptance.
